// File: rtl/sha_256_pkg.sv
// Shared types and widths for the SHA-256 block sequencer and its word packer.
package sha_256_pkg;

   typedef enum logic [1:0] {FILL, START, WAIT, OUT} seq_state_t;

   localparam int WORDS_PER_BLOCK = 16;
   localparam int WORD_W          = 32;
   localparam int BLOCK_W         = 512;
   localparam int DIGEST_W        = 256;

endpackage

// File: rtl/sha_256_block_packer.sv
// Packs 32-bit message words big-endian into a 512-bit block and flags an early s_last.
// Word n of each block lands in msg[511-32n -: 32]; the block is held until the next accept.
module sha_256_block_packer
   import sha_256_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 accept,
   input  logic [WORD_W-1:0]                    data,
   input  logic                                 last,
   output logic [BLOCK_W-1:0]                   msg,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0]   word_idx,
   output logic                                 block_done,
   output logic                                 last_err
);

   localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

   logic [8:0] base;

   // MSB index of the current word slot: 511 - 32*n
   assign base       = 9'(BLOCK_W - 1) - {word_idx, 5'b0};
   assign block_done = accept && (word_idx == IDX_W'(WORDS_PER_BLOCK - 1));
   assign last_err   = accept && last && (word_idx != IDX_W'(WORDS_PER_BLOCK - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         msg      <= '0;
         word_idx <= '0;
      end else if (accept) begin
         msg[base -: WORD_W] <= data;
         word_idx            <= word_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/sha_256_block_sequencer.sv
// Front-end controller feeding 512-bit blocks to the SHA-256 core and returning the final digest.
// Optional WAIT watchdog enabled by defining SHA_SEQ_TIMEOUT_EN.
module sha_256_block_sequencer
   import sha_256_pkg::*;
#(
   parameter int MAX_BLOCKS     = 256,
   parameter int TIMEOUT_CYCLES = 127
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [WORD_W-1:0]                 s_data,
   input  logic                              s_last,
   output logic [BLOCK_W-1:0]                core_msg,
   output logic                              core_start,
   input  logic                              core_hash_ready,
   input  logic [DIGEST_W-1:0]               core_result,
   output logic                              d_valid,
   input  logic                              d_ready,
   output logic [DIGEST_W-1:0]               d_digest,
   output logic                              busy,
   output logic [$clog2(MAX_BLOCKS+1)-1:0]   blk_count,
   output logic                              err
);

   localparam int BC_W  = $clog2(MAX_BLOCKS + 1);
   localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

   seq_state_t        state;
   logic              last_flag;
   logic              accept;
   logic [IDX_W-1:0]  word_idx;
   logic              block_done;
   logic              last_err;
   logic              hash_in_wait;
   logic              hash_stray;
   logic              blk_sat;
   logic              handshake;
   logic              timeout;

   assign s_ready      = (state == FILL);
   assign accept       = s_valid && s_ready;
   assign core_start   = (state == START);
   assign d_valid      = (state == OUT);
   assign busy         = (state != FILL) || (word_idx != '0);
   assign handshake    = d_valid && d_ready;
   assign hash_in_wait = core_hash_ready && (state == WAIT);
   assign hash_stray   = core_hash_ready && (state != WAIT);
   assign blk_sat      = (blk_count == BC_W'(MAX_BLOCKS));

   sha_256_block_packer u_packer (
      .clk        (clk),
      .rstn       (rstn),
      .accept     (accept),
      .data       (s_data),
      .last       (s_last),
      .msg        (core_msg),
      .word_idx   (word_idx),
      .block_done (block_done),
      .last_err   (last_err)
   );

`ifdef SHA_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wdog;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wdog <= '0;
      end else if (state == START) begin
         wdog <= '0;
      end else if (state == WAIT) begin
         wdog <= wdog + WD_W'(1);
      end
   end

   // fires on the edge that ends the TIMEOUT_CYCLES-th WAIT cycle; a real hash_ready wins
   assign timeout = (state == WAIT) && !core_hash_ready && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= FILL;
         last_flag <= 1'b0;
         blk_count <= '0;
         d_digest  <= '0;
         err       <= 1'b0;
      end else begin
         if (last_err || hash_stray || timeout || (hash_in_wait && blk_sat)) begin
            err <= 1'b1;
         end
         case (state)
            FILL: begin
               if (block_done) begin
                  last_flag <= s_last;
                  state     <= START;
               end
            end
            START: state <= WAIT;
            WAIT: begin
               if (hash_in_wait) begin
                  if (!blk_sat) begin
                     blk_count <= blk_count + BC_W'(1);
                  end
                  if (last_flag) begin
                     d_digest <= core_result;
                     state    <= OUT;
                  end else begin
                     state <= FILL;
                  end
               end else if (timeout) begin
                  blk_count <= '0;
                  state     <= FILL;
               end
            end
            OUT: begin
               if (handshake) begin
                  blk_count <= '0;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sha_256_block_sequencer.sv
// Bench for sha_256_block_sequencer with a behavioural SHA-256 core attached.
module tb_sha_256_block_sequencer;
   import sha_256_pkg::*;

   localparam int MAXB = 256;
   localparam int TO   = 10;
   localparam int BCW  = $clog2(MAXB + 1);

   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [2047:0] KT = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
   localparam logic [511:0] BLK_M1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_M2  = {{15{32'h00000000}}, 32'h000001c0};
   localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_M   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic            clk = 1'b0;
   logic            rstn;
   logic            s_valid;
   logic            s_ready;
   logic [31:0]     s_data;
   logic            s_last;
   logic [511:0]    core_msg;
   logic            core_start;
   logic            core_hash_ready;
   logic [255:0]    core_result;
   logic            d_valid;
   logic            d_ready;
   logic [255:0]    d_digest;
   logic            busy;
   logic [BCW-1:0]  blk_count;
   logic            err;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   logic [255:0] exp_q[$];
   logic [511:0] blk_q[$];

   logic         core_en;
   int           core_lat;
   logic [255:0] h_reg;
   logic [511:0] blk_reg;
   logic         pend;
   int           cnt;

   always #5 clk = ~clk;

   sha_256_block_sequencer #(.MAX_BLOCKS(MAXB), .TIMEOUT_CYCLES(TO)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_data          (s_data),
      .s_last          (s_last),
      .core_msg        (core_msg),
      .core_start      (core_start),
      .core_hash_ready (core_hash_ready),
      .core_result     (core_result),
      .d_valid         (d_valid),
      .d_ready         (d_ready),
      .d_digest        (d_digest),
      .busy            (busy),
      .blk_count       (blk_count),
      .err             (err)
   );

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1, ch, mj;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
         s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, hh} = h;
      for (int i = 0; i < 64; i++) begin
         s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
         ch = (e & f) ^ (~e & g);
         t1 = hh + s1 + ch + KT[2047 - 32*i -: 32] + w[i];
         s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
         mj = (a & b) ^ (a & c) ^ (b & c);
         t2 = s0 + mj;
         hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
              h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
   endfunction

   // Core stand-in: chains the hash across blocks, restarts only on rstn.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         h_reg           <= IV;
         blk_reg         <= '0;
         pend            <= 1'b0;
         cnt             <= 0;
         core_hash_ready <= 1'b0;
      end else begin
         core_hash_ready <= 1'b0;
         if (core_start && core_en) begin
            pend    <= 1'b1;
            cnt     <= core_lat;
            blk_reg <= core_msg;
         end else if (pend) begin
            if (cnt == 0) begin
               pend            <= 1'b0;
               core_hash_ready <= 1'b1;
               h_reg           <= sha_compress(h_reg, blk_reg);
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end
   assign core_result = h_reg;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   logic         prev_hr;
   logic         hold_pend;
   logic [255:0] hold_dig;

   always @(negedge clk) begin
      if (!rstn) begin
         prev_hr   = 1'b0;
         hold_pend = 1'b0;
      end else begin
         if (core_start) begin
            start_cnt++;
            if (blk_q.size() == 0) chk("core_start_unexpected", core_start, 1'b0);
            else                   chk("core_msg_at_start", core_msg, blk_q.pop_front());
         end
         if (core_hash_ready && core_en) chk("core_msg_held", core_msg, blk_reg);
         if (prev_hr) chk("hash_ready_latency", d_valid || s_ready, 1'b1);
         if (d_valid && hold_pend) chk("digest_hold", d_digest, hold_dig);
         if (d_valid && d_ready) begin
            if (exp_q.size() == 0) chk("digest_unexpected", d_valid, 1'b0);
            else                   chk("digest", d_digest, exp_q.pop_front());
         end
         prev_hr   = core_hash_ready;
         hold_pend = d_valid && !d_ready;
         hold_dig  = d_digest;
      end
   end

   task automatic do_reset();
      rstn = 1'b0;
      exp_q.delete();
      blk_q.delete();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Sends one block; returns in the cycle after the word-15 accept edge.
   task automatic send_block(input logic [511:0] blk, input logic last, input bit rnd, input int early);
      blk_q.push_back(blk);
      for (int i = 0; i < 16; i++) begin
         int t = 0;
         if (rnd) begin
            for (int k = 0; k < 4 && $urandom_range(0, 2) == 0; k++) begin
               s_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         s_valid = 1'b1;
         s_data  = blk[511 - 32*i -: 32];
         s_last  = (i == 15) ? last : (i == early);
         while (!s_ready && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
         end
         if (t >= 2000) chk("s_ready_timeout", 32'(t), 32'd0);
         @(posedge clk);
         #1;
         s_valid = 1'b0;
         s_last  = 1'b0;
         if (i == early) chk("err_after_early_last", err, 1'b1);
      end
   endtask

   task automatic wait_dvalid();
      int t = 0;
      while (!d_valid && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 3000) chk("d_valid_timeout", 32'(t), 32'd0);
   endtask

   task automatic wait_digest();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 3000) chk("digest_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      rstn     = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      d_ready  = 1'b1;
      core_en  = 1'b1;
      core_lat = 6;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", s_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_blk_count", blk_count, '0);
      chk("rst_core_msg", core_msg, '0);
      chk("rst_d_digest", d_digest, '0);
      chk("rst_core_start", core_start, 1'b0);
      chk("rst_d_valid", d_valid, 1'b0);
      chk("rst_err", err, 1'b0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // single "abc" block
      base = start_cnt;
      exp_q.push_back(DIG_ABC);
      send_block(BLK_ABC, 1'b1, 1'b0, -1);
      chk("abc_start_latency", core_start, 1'b1);
      chk("abc_busy_start", busy, 1'b1);
      @(posedge clk);
      #1;
      chk("abc_start_single", core_start, 1'b0);
      chk("abc_s_ready_wait", s_ready, 1'b0);
      wait_dvalid();
      chk("abc_blk_count", blk_count, BCW'(1));
      chk("abc_start_count", 32'(start_cnt - base), 32'd1);
      wait_digest();
      @(posedge clk);
      #1;
      chk("abc_blk_count_clr", blk_count, '0);
      chk("abc_s_ready_after", s_ready, 1'b1);
      chk("abc_busy_after", busy, 1'b0);
      chk("abc_err", err, 1'b0);

      // two-block message
      do_reset();
      base = start_cnt;
      exp_q.push_back(DIG_M);
      send_block(BLK_M1, 1'b0, 1'b0, -1);
      chk("m2_s_ready_start", s_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("m2_s_ready_wait", s_ready, 1'b0);
      send_block(BLK_M2, 1'b1, 1'b0, -1);
      wait_dvalid();
      chk("m2_blk_count", blk_count, BCW'(2));
      chk("m2_start_count", 32'(start_cnt - base), 32'd2);
      wait_digest();

      // random s_valid gaps, digest held under d_ready low
      do_reset();
      d_ready = 1'b0;
      exp_q.push_back(DIG_M);
      send_block(BLK_M1, 1'b0, 1'b1, -1);
      send_block(BLK_M2, 1'b1, 1'b1, -1);
      wait_dvalid();
      chk("bp_blk_count", blk_count, BCW'(2));
      repeat (20) @(posedge clk);
      #1;
      chk("bp_d_valid_held", d_valid, 1'b1);
      chk("bp_s_ready_held", s_ready, 1'b0);
      d_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_d_valid_drop", d_valid, 1'b0);
      chk("bp_blk_count_clr", blk_count, '0);
      wait_digest();

      // early s_last on word 7
      do_reset();
      chk("early_err_before", err, 1'b0);
      exp_q.push_back(DIG_ABC);
      send_block(BLK_ABC, 1'b1, 1'b0, 7);
      chk("early_start", core_start, 1'b1);
      wait_dvalid();
      wait_digest();
      chk("early_err_sticky", err, 1'b1);

      // reset while waiting on the core, then a full message
      do_reset();
      core_lat = 30;
      exp_q.push_back(DIG_ABC);
      send_block(BLK_ABC, 1'b1, 1'b0, -1);
      repeat (4) @(posedge clk);
      #1;
      chk("rw_busy_wait", busy, 1'b1);
      rstn = 1'b0;
      #1;
      chk("rw_s_ready", s_ready, 1'b1);
      chk("rw_busy", busy, 1'b0);
      chk("rw_blk_count", blk_count, '0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      core_lat = 6;
      exp_q.push_back(DIG_M);
      send_block(BLK_M1, 1'b0, 1'b0, -1);
      send_block(BLK_M2, 1'b1, 1'b0, -1);
      wait_digest();
      chk("rw_err", err, 1'b0);

      // core never answers
      do_reset();
      core_en = 1'b0;
      send_block(BLK_ABC, 1'b1, 1'b0, -1);
`ifdef SHA_SEQ_TIMEOUT_EN
      begin
         int k = 0;
         while (!err && k < 60) begin
            @(posedge clk);
            #1;
            k++;
         end
         // err rises on the edge that ends the TO-th WAIT cycle
         chk("to_latency", 32'(k), 32'(TO + 1));
         chk("to_s_ready", s_ready, 1'b1);
         chk("to_busy", busy, 1'b0);
         chk("to_blk_count", blk_count, '0);
      end
`else
      repeat (200) @(posedge clk);
      #1;
      chk("nto_s_ready", s_ready, 1'b0);
      chk("nto_busy", busy, 1'b1);
      chk("nto_err", err, 1'b0);
      chk("nto_d_valid", d_valid, 1'b0);
`endif
      core_en = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha_256_block_sequencer.md
Name: sha_256_block_sequencer

Overview:
- Front-end controller for the SHA-256 core (sha_256_top).
- Accepts the message as a stream of 32-bit words over a valid/ready handshake and packs every 16 words into a 512-bit block.
- Pulses the core's start for each block, waits for the core's hash_ready, and chains blocks until the message's last block; presents the final 256-bit digest over a valid/ready handshake.
- Message padding is done upstream. The stream is whole 512-bit blocks.

Parameters:
- MAX_BLOCKS, 256, maximum blocks per message; width of blk_count is $clog2(MAX_BLOCKS+1).
- TIMEOUT_CYCLES, 127, watchdog limit in WAIT (used only when SHA_SEQ_TIMEOUT_EN is defined).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  sequencer can accept a word
- s_data  in  32  message word, big-endian order within the block
- s_last  in  1  word is the final word of the message
- core_msg  out  512  block to the core (input_msg_digest); stable from start until hash_ready
- core_start  out  1  single-cycle start pulse to the core
- core_hash_ready  in  1  core round-complete pulse; core_result is valid in the same cycle
- core_result  in  256  core chained hash (sha_result)
- d_valid  out  1  digest valid
- d_ready  in  1  digest consumer ready
- d_digest  out  256  final digest
- busy  out  1  high in any state other than FILL with word count 0
- blk_count  out  clog2  blocks completed in the current message
- err  out  1  sticky protocol or timeout error; cleared only by reset

Behaviour:
- Reset: clk is the only clock; rstn is asynchronous, active-low.
  - State FILL, word count 0, blk_count 0, core_msg 0, d_digest 0.
  - core_start, d_valid, busy and err are 0; s_ready is 1.
- The sequencer never resets the core. The core's chaining registers restart only via the shared rstn; one message per rstn epoch is the supported usage.
- FILL:
  - s_ready=1.
  - On each s_valid&&s_ready, word n (0..15) is written to core_msg[511-32n -: 32], then n increments.
  - s_last on word n<15: err set, s_last ignored, fill continues.
  - On the accept of word 15: latch last_flag=s_last, n wraps to 0, go to START.
- START: core_start=1 for exactly one cycle; s_ready=0; go to WAIT.
- WAIT:
  - s_ready=0; core_msg is held.
  - On core_hash_ready: blk_count increments.
    - blk_count saturates at MAX_BLOCKS; an increment beyond it sets err.
    - If last_flag: capture d_digest=core_result and go to OUT.
    - Otherwise go to FILL.
  - A core_hash_ready pulse in any state other than WAIT is ignored and sets err.
- OUT:
  - d_valid=1, with d_digest stable until d_valid&&d_ready.
  - On the handshake: d_valid=0 next cycle, blk_count cleared, go to FILL.
  - s_ready stays 0 until the handshake completes.
- Latency:
  - Word 15 accepted at cycle T: core_start asserts at T+1.
  - hash_ready at cycle H: d_valid at H+1, or s_ready at H+1 for a non-last block.
- Reset mid-operation: all state is cleared immediately, and any partial block is discarded.

Optional Feature:
- Macro SHA_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter is cleared on entry to WAIT and increments each cycle spent in WAIT.
  - Reaching TIMEOUT_CYCLES sets err, drops the block, clears blk_count, and returns to FILL with n=0.
- Undefined: no watchdog counter exists, and WAIT waits indefinitely.

Decomposition:
- Package sha_256_pkg:
  - typedef enum logic [1:0] {FILL, START, WAIT, OUT} seq_state_t
  - localparam WORDS_PER_BLOCK=16
  - localparam WORD_W=32
  - localparam BLOCK_W=512
  - localparam DIGEST_W=256
- One natural sub-module: sha_256_block_packer, covering the word counter, shift into core_msg, and the last-word check. The FSM and output register stay in the sequencer.

Test Plan:
- Single block "abc" padded (word0 32'h61626380, words 1..14 zero, word15 32'h00000018, s_last on word15) with the core attached → d_digest 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; core_start pulses once; blk_count 1.
- Two-block message "abcdbcdecdef…nopq" (448 bits), padded to 2 blocks, s_last on word 31 → core_start pulses twice; s_ready drops during each WAIT; final digest 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- s_valid toggled randomly and d_ready held low 20 cycles → d_valid and d_digest stable throughout; blk_count clears after the handshake; no lost or duplicated words.
- s_last on word 7 → err=1 from the next cycle onward; block still completes after 16 words.
- rstn asserted in WAIT → s_ready=1, busy=0, blk_count=0 immediately; a subsequent full message hashes correctly.
- SHA_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, core_hash_ready stubbed to 0 → err set 10 cycles after core_start; state returns to FILL with s_ready=1.
